// File: rtl/dc_chan_sched.sv
// Three-channel DC scheduler: serialises Y/Cb/Cr DCs in MCU order onto the mode/dc_data/dc_done bus.
// Latency 1 cycle handshake-to-strobe; only the selected channel sees ready, the others are held off.
module dc_chan_sched #(
  parameter int BLOCKS_PER_CH = 64,
  parameter int Y_PER_MCU     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        y_valid,
  input  logic [11:0] y_data,
  output logic        y_ready,
  input  logic        cb_valid,
  input  logic [11:0] cb_data,
  output logic        cb_ready,
  input  logic        cr_valid,
  input  logic [11:0] cr_data,
  output logic        cr_ready,
  output logic [1:0]  mode,
  output logic [11:0] dc_data,
  output logic        dc_done,
  output logic        busy,
  output logic [7:0]  mcu_idx,
  output logic        frame_done,
  output logic        start_err
);

  typedef enum logic [1:0] {IDLE, SEL_Y, SEL_CB, SEL_CR} state_t;

  localparam logic [7:0] LAST_MCU = 8'(BLOCKS_PER_CH - 1);
  localparam logic [1:0] LAST_Y   = 2'(Y_PER_MCU - 1);

  state_t     state;
  logic [1:0] y_cnt;
  logic       y_acc, cb_acc, cr_acc;

  assign y_ready  = (state == SEL_Y);
  assign cb_ready = (state == SEL_CB);
  assign cr_ready = (state == SEL_CR);

  assign y_acc  = y_valid  && y_ready;
  assign cb_acc = cb_valid && cb_ready;
  assign cr_acc = cr_valid && cr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      y_cnt      <= 2'd0;
      mode       <= 2'b00;
      dc_data    <= 12'd0;
      dc_done    <= 1'b0;
      busy       <= 1'b0;
      mcu_idx    <= 8'd0;
      frame_done <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      dc_done    <= 1'b0;
      mode       <= 2'b00;
      frame_done <= 1'b0;
      start_err  <= start && (state != IDLE);
      // abort outranks any handshake completing in the same cycle
      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        busy    <= 1'b0;
        mcu_idx <= 8'd0;
        y_cnt   <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= SEL_Y;
              busy    <= 1'b1;
              mcu_idx <= 8'd0;
              y_cnt   <= 2'd0;
            end
          end
          SEL_Y: begin
            if (y_acc) begin
              dc_done <= 1'b1;
              mode    <= 2'b01;
              dc_data <= y_data;
              if (y_cnt == LAST_Y) begin
                y_cnt <= 2'd0;
                state <= SEL_CB;
              end else begin
                y_cnt <= y_cnt + 2'd1;
              end
            end
          end
          SEL_CB: begin
            if (cb_acc) begin
              dc_done <= 1'b1;
              mode    <= 2'b11;
              dc_data <= cb_data;
              state   <= SEL_CR;
            end
          end
          SEL_CR: begin
            if (cr_acc) begin
              dc_done <= 1'b1;
              mode    <= 2'b10;
              dc_data <= cr_data;
              if (mcu_idx == LAST_MCU) begin
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                mcu_idx <= mcu_idx + 8'd1;
                state   <= SEL_Y;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dc_chan_sched.md
# dc_chan_sched

Three-channel DC coefficient scheduler in front of the EPU DPCM units. It accepts DC values from separate Y, Cb and Cr producers over valid/ready handshakes and serialises them in MCU order. It drives the shared `mode` / `dc_data` / `dc_done` bus that the per-channel DPCM stages decode, and it counts blocks per frame. It raises `frame_done` alongside the final DC of the frame.

## Interface
- `BLOCKS_PER_CH`, 64: MCUs per frame (1..256); each DPCM channel unit expects this many chroma DCs.
- `Y_PER_MCU`, 1: Y blocks per MCU (1..4).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle pulse; begins a frame when idle.
- `abort` in 1: synchronous; kills the current frame.
- `y_valid` in 1; `y_data` in 12; `y_ready` out 1: Y DC handshake.
- `cb_valid` in 1; `cb_data` in 12; `cb_ready` out 1: Cb DC handshake.
- `cr_valid` in 1; `cr_data` in 12; `cr_ready` out 1: Cr DC handshake.
- `mode` out 2: channel tag of the current transfer. Y=01, Cr=10, Cb=11, 00 when `dc_done`=0.
- `dc_data` out 12: DC value, two's complement, passed unmodified.
- `dc_done` out 1: one-cycle strobe per DC value.
- `busy` out 1: high from the accepted `start` until the frame ends or is aborted.
- `mcu_idx` out 8: index of the MCU currently being collected.
- `frame_done` out 1: one-cycle pulse coincident with the last `dc_done` of the frame.
- `start_err` out 1: one-cycle pulse when `start` arrives while `busy`.

## Operation
- State machine states: IDLE, SEL_Y, SEL_CB, SEL_CR.
- Ready outputs are combinational from state only: `y_ready`=(SEL_Y), `cb_ready`=(SEL_CB), `cr_ready`=(SEL_CR). Ready never depends on valid. At most one ready is high in any cycle.
- IDLE:
  - `start` goes to SEL_Y and clears `mcu_idx` and `y_cnt`.
  - `abort` is ignored.
- SEL_Y:
  - Each accept (valid&&ready) increments `y_cnt`.
  - The accept with `y_cnt`==Y_PER_MCU-1 clears `y_cnt` and goes to SEL_CB.
- SEL_CB: one accept goes to SEL_CR.
- SEL_CR, on its accept:
  - If `mcu_idx`==BLOCKS_PER_CH-1, go to IDLE and assert `frame_done`.
  - Otherwise increment `mcu_idx` and go to SEL_Y.
- Valid on a non-selected channel is held off (no ready). Its data must stay stable at the producer; the scheduler never drops or reorders values.
- `abort` in any non-IDLE state:
  - Next state is IDLE; counters clear.
  - No `frame_done`.
  - A handshake completing in the same cycle is discarded: no `dc_done` for it.
- `start` while busy: ignored, `start_err` pulses, frame continues. `start` and `abort` in the same cycle while busy: abort wins, `start_err` still pulses.
- Data path width: 12 bits in and out, no arithmetic. Counters: `mcu_idx` 8 bits, `y_cnt` 2 bits; neither wraps, because the state machine leaves before overflow.
- Per frame, exactly Y_PER_MCU·BLOCKS_PER_CH Y strobes, BLOCKS_PER_CH Cb strobes and BLOCKS_PER_CH Cr strobes are emitted.

## Timing
- Reset values:
  - State IDLE.
  - All readies 0.
  - `mode`=00, `dc_data`=0, `dc_done`=0.
  - `busy`=0, `mcu_idx`=0, `frame_done`=0, `start_err`=0.
- Latency: a handshake at cycle N gives registered `dc_done`=1 with matching `mode`/`dc_data` at cycle N+1.
- Throughput: with valid held high, one DC per cycle. Ready of the next channel rises the cycle after the previous accept.
- `busy` is registered: it rises the cycle after `start` and falls the cycle after the final accept or abort, i.e. together with `frame_done`.
- `mcu_idx` updates the cycle after the Cr accept.
- Asynchronous `rst` mid-frame: all outputs return to reset values immediately. A `dc_done` in flight is lost. The downstream DPCM units must share the same reset.

## Test plan
- Default params, `start`, all three valids held high with incrementing data:
  - 192 `dc_done` strobes in order Y,Cb,Cr repeating, `mode` 01,11,10.
  - `frame_done` coincides with the 192nd strobe, which carries Cr data.
  - `busy` high for 192 cycles.
- Y_PER_MCU=4, BLOCKS_PER_CH=2: strobe sequence Y,Y,Y,Y,Cb,Cr,Y,Y,Y,Y,Cb,Cr; `mcu_idx` 0 then 1; 12 strobes total.
- Random valid gaps on each channel (≈50% duty), default params:
  - Scoreboard confirms no lost or duplicated values and no `dc_done` without a prior accept.
  - Readies stay one-hot or zero.
- `abort` asserted on the same cycle as the 10th accept:
  - Only 9 strobes appear; no `frame_done`.
  - `busy` drops next cycle.
  - A following `start` restarts at `mcu_idx`=0 with Y.
- `start` pulsed at MCU 5 of a running frame: `start_err` pulses once, sequence and counts unaffected.
- `rst` asserted mid-frame at MCU 30 with `dc_done` high: all outputs 0 asynchronously; after release, state is IDLE and readies are 0 until `start`.
